dtc_class_decoder: RTL and testbench



---
 rtl/dtc_pkg.sv | 21 ++
 rtl/dtc_prio_enc.sv | 35 +++
 rtl/dtc_class_decoder.sv | 124 ++++++++++++
 tb/tb_dtc_class_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
// Shared types and constants for the decision-tree class post-processing blocks.
package dtc_pkg;

    localparam int DTC_NUM_CLASSES = 77;
    localparam int DTC_IDX_W       = $clog2(DTC_NUM_CLASSES);
    localparam int DTC_STAT_W      = 16;

    typedef struct packed {
        logic [DTC_IDX_W-1:0] idx;
        logic                 none;
        logic                 multi;
    } dtc_result_t;

    // Saturating +1 used by the event counters; sticks at all-ones.
    function automatic logic [DTC_STAT_W-1:0] dtc_sat_inc(input logic [DTC_STAT_W-1:0] v);
        logic [DTC_STAT_W-1:0] one;
        one = {{(DTC_STAT_W-1){1'b0}}, 1'b1};
        return (v == {DTC_STAT_W{1'b1}}) ? v : (v + one);
    endfunction

endpackage

// File: rtl/dtc_prio_enc.sv
// Combinational lowest-set-bit encoder with empty / multiple-bit flags for
// one-hot class vectors; reusable by any tree post-processor.
module dtc_prio_enc #(
    parameter int NUM_CLASSES = 77,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic [NUM_CLASSES-1:0] i_vec,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_none,
    output logic                   o_multi
);

    logic [NUM_CLASSES-1:0] w_vec_minus1;
    logic [NUM_CLASSES-1:0] w_low_cleared;

    // Clearing the lowest set bit leaves something behind only if two or more were set.
    always_comb begin
        w_vec_minus1  = i_vec - {{(NUM_CLASSES-1){1'b0}}, 1'b1};
        w_low_cleared = i_vec & w_vec_minus1;
        o_none        = ~(|i_vec);
        o_multi       = |w_low_cleared;
    end

    // Priority scan: the first set bit found from index 0 upward wins.
    always_comb begin
        logic found;
        o_idx = {IDX_W{1'b0}};
        found = 1'b0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            o_idx = (!found && i_vec[k]) ? IDX_W'(k) : o_idx;
            found = found | i_vec[k];
        end
    end

endmodule

// File: rtl/dtc_class_decoder.sv
// Two-stage valid/ready decoder from one-hot class vector to class index.
// Optional saturating output statistics are enabled with `define DTC_DEC_STATS_EN.
module dtc_class_decoder
    import dtc_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DTC_NUM_CLASSES-1:0] in_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DTC_IDX_W-1:0]       out_idx,
    output logic                       out_none,
    output logic                       out_multi
`ifdef DTC_DEC_STATS_EN
    ,
    output logic [DTC_STAT_W-1:0]      stat_total,
    output logic [DTC_STAT_W-1:0]      stat_none,
    output logic [DTC_STAT_W-1:0]      stat_multi
`endif
);

    localparam int NUM_CLASSES = DTC_NUM_CLASSES;
    localparam int IDX_W       = DTC_IDX_W;

    logic                   r_s1_valid;
    logic [NUM_CLASSES-1:0] r_s1_vec;
    logic                   r_s2_valid;
    dtc_result_t            r_s2_res;

    logic                   w_s2_adv;
    logic                   w_in_fire;
    logic                   w_s1_move;
    logic                   w_out_fire;
    logic [IDX_W-1:0]       w_enc_idx;
    logic                   w_enc_none;
    logic                   w_enc_multi;

    // Handshake decode; in_ready deliberately sees out_ready combinationally.
    always_comb begin
        w_s2_adv   = ~r_s2_valid | out_ready;
        in_ready   = ~r_s1_valid | w_s2_adv;
        w_in_fire  = in_valid & in_ready;
        w_s1_move  = r_s1_valid & w_s2_adv;
        w_out_fire = r_s2_valid & out_ready;
    end

    dtc_prio_enc #(
        .NUM_CLASSES (NUM_CLASSES),
        .IDX_W       (IDX_W)
    ) u_prio_enc (
        .i_vec   (r_s1_vec),
        .o_idx   (w_enc_idx),
        .o_none  (w_enc_none),
        .o_multi (w_enc_multi)
    );

    // Stage valid flags: a new arrival keeps S1 full, S2 refills from S1 whenever it may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
            end else if (w_s1_move) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
        end
    end

    // Raw vector is only ever observed while r_s1_valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_vec <= in_vec;
        end
    end

    // Encoded result register; reset so the idle output bus reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_res <= '0;
        end else if (w_s1_move) begin
            r_s2_res <= '{idx: w_enc_idx, none: w_enc_none, multi: w_enc_multi};
        end
    end

    assign out_valid = r_s2_valid;
    assign out_idx   = r_s2_res.idx;
    assign out_none  = r_s2_res.none;
    assign out_multi = r_s2_res.multi;

`ifdef DTC_DEC_STATS_EN
    logic [DTC_STAT_W-1:0] r_stat_total;
    logic [DTC_STAT_W-1:0] r_stat_none;
    logic [DTC_STAT_W-1:0] r_stat_multi;

    // Per-handshake event counters, saturating, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_total <= {DTC_STAT_W{1'b0}};
            r_stat_none  <= {DTC_STAT_W{1'b0}};
            r_stat_multi <= {DTC_STAT_W{1'b0}};
        end else if (w_out_fire) begin
            r_stat_total <= dtc_sat_inc(r_stat_total);
            if (r_s2_res.none) begin
                r_stat_none <= dtc_sat_inc(r_stat_none);
            end
            if (r_s2_res.multi) begin
                r_stat_multi <= dtc_sat_inc(r_stat_multi);
            end
        end
    end

    assign stat_total = r_stat_total;
    assign stat_none  = r_stat_none;
    assign stat_multi = r_stat_multi;
`endif

endmodule

// File: tb/tb_dtc_class_decoder.sv
// Scoreboard bench for dtc_class_decoder; stats checks compile in with DTC_DEC_STATS_EN.
module tb_dtc_class_decoder;
    import dtc_pkg::*;

    logic                       clk;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic [DTC_NUM_CLASSES-1:0] in_vec;
    logic                       out_valid;
    logic                       out_ready;
    logic [DTC_IDX_W-1:0]       out_idx;
    logic                       out_none;
    logic                       out_multi;
`ifdef DTC_DEC_STATS_EN
    logic [DTC_STAT_W-1:0]      stat_total;
    logic [DTC_STAT_W-1:0]      stat_none;
    logic [DTC_STAT_W-1:0]      stat_multi;
`endif

    int          n_checks = 0;
    int          n_fails  = 0;
    dtc_result_t sb_q[$];
    logic        rnd_done;

    dtc_class_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_multi (out_multi)
`ifdef DTC_DEC_STATS_EN
        ,
        .stat_total(stat_total),
        .stat_none (stat_none),
        .stat_multi(stat_multi)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DTC_NUM_CLASSES-1:0] onehot(input int k);
        logic [DTC_NUM_CLASSES-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic dtc_result_t model(input logic [DTC_NUM_CLASSES-1:0] v);
        dtc_result_t r;
        int          cnt;
        cnt   = $countones(v);
        r.idx = '0;
        for (int k = DTC_NUM_CLASSES - 1; k >= 0; k--) begin
            if (v[k]) r.idx = 7'(k);
        end
        r.none  = (cnt == 0);
        r.multi = (cnt >= 2);
        return r;
    endfunction

    // Push expected results at accept, compare at output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    dtc_result_t e;
                    e = sb_q.pop_front();
                    check_eq("sb_idx",   32'(out_idx),   32'(e.idx));
                    check_eq("sb_none",  32'(out_none),  32'(e.none));
                    check_eq("sb_multi", 32'(out_multi), 32'(e.multi));
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in_vec));
            end
        end
    end

    // Present a vector and return just after the edge that accepts it.
    task automatic drive(input logic [DTC_NUM_CLASSES-1:0] v);
        int n;
        in_vec   = v;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DTC_NUM_CLASSES-1:0] rand_vec();
        logic [95:0]                tmp;
        logic [DTC_NUM_CLASSES-1:0] v;
        tmp = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       v = '0;
            1:       v = onehot($urandom_range(0, DTC_NUM_CLASSES - 1));
            2:       v = onehot($urandom_range(0, DTC_NUM_CLASSES - 1)) | onehot($urandom_range(0, DTC_NUM_CLASSES - 1));
            default: v = tmp[DTC_NUM_CLASSES-1:0];
        endcase
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DTC_NUM_CLASSES-1:0] v;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        rnd_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_idx",   32'(out_idx),   32'd0);
        check_eq("rst_out_none",  32'(out_none),  32'd0);
        check_eq("rst_out_multi", 32'(out_multi), 32'd0);
`ifdef DTC_DEC_STATS_EN
        check_eq("rst_stat_total", 32'(stat_total), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Latency: accept cycle, one empty cycle, then the result.
        @(posedge clk);
        #1;
        in_vec   = onehot(11);
        in_valid = 1'b1;
        @(negedge clk);
        check_eq("lat_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_c1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_c2_valid", 32'(out_valid), 32'd1);
        check_eq("lat_c2_idx",   32'(out_idx),   32'd11);
        check_eq("lat_c2_none",  32'(out_none),  32'd0);
        check_eq("lat_c2_multi", 32'(out_multi), 32'd0);
        wait_drain();

        // Boundary vectors.
        drive('0);
        drive(onehot(5) | onehot(40));
        drive(onehot(76));
        in_valid = 1'b0;
        wait_drain();

        // Back-to-back stream must come out without bubbles.
        fork
            begin
                for (int i = 0; i < 10; i++) drive(onehot(i));
                in_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 10; i++) begin
                    check_eq("stream_nobubble", 32'(out_valid), 32'd1);
                    check_eq("stream_idx", 32'(out_idx), 32'(i));
                    @(negedge clk);
                end
                check_eq("stream_end", 32'(out_valid), 32'd0);
            end
        join
        wait_drain();

        // Backpressure: two stages fill, third sample waits, output holds.
        out_ready = 1'b0;
        drive(onehot(3));
        drive(onehot(4));
        in_vec   = onehot(5);
        in_valid = 1'b1;
        @(negedge clk);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_valid",    32'(out_valid), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_hold_idx", 32'(out_idx),  32'd3);
            check_eq("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_rel_idx3",  32'(out_idx),  32'd3);
        check_eq("bp_rel_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("bp_rel_v4",   32'(out_valid), 32'd1);
        check_eq("bp_rel_idx4", 32'(out_idx),   32'd4);
        @(negedge clk);
        check_eq("bp_rel_v5",   32'(out_valid), 32'd1);
        check_eq("bp_rel_idx5", 32'(out_idx),   32'd5);
        @(negedge clk);
        check_eq("bp_rel_empty", 32'(out_valid), 32'd0);
        wait_drain();

        // Reset while both stages hold data.
        out_ready = 1'b0;
        drive(onehot(7));
        drive(onehot(8));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid_ready", 32'(in_ready),  32'd1);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_vec    = onehot(9);
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_new_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("rst_new_valid", 32'(out_valid), 32'd1);
        check_eq("rst_new_idx",   32'(out_idx),   32'd9);
        @(negedge clk);
        check_eq("rst_new_alone", 32'(out_valid), 32'd0);
        wait_drain();

        // Random traffic with random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) drive(rand_vec());
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

`ifdef DTC_DEC_STATS_EN
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive('0);
        drive(onehot(1) | onehot(2));
        drive('0);
        for (int i = 20; i < 27; i++) drive(onehot(i));
        in_valid = 1'b0;
        wait_drain();
        check_eq("stat_total", 32'(stat_total), 32'd10);
        check_eq("stat_none",  32'(stat_none),  32'd2);
        check_eq("stat_multi", 32'(stat_multi), 32'd1);
        force dut.r_stat_total = 16'hFFFF;
        #1;
        release dut.r_stat_total;
        drive(onehot(30));
        in_valid = 1'b0;
        wait_drain();
        check_eq("stat_sat_total", 32'(stat_total), 32'h0000_FFFF);
        check_eq("stat_sat_none",  32'(stat_none),  32'd2);
`endif

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
